// File: rtl/dm_pkg.sv
// Shared types and default sizes for the data-memory responder.
// Host FSM states, access-kind encoding and read-data owner tags.
package dm_pkg;

   localparam int DM_ADDR_WIDTH = 12;
   localparam int DM_DATA_WIDTH = 32;
   localparam int DM_DEPTH      = 4096;
   localparam int DM_CNT_WIDTH  = 16;

   typedef enum logic [1:0] {
      H_IDLE = 2'b00,
      H_WAIT = 2'b01,
      H_ACK  = 2'b10
   } host_state_t;

   typedef enum logic [1:0] {
      CMD_NONE  = 2'b00,
      CMD_READ  = 2'b01,
      CMD_WRITE = 2'b10
   } dm_cmd_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_CORE = 2'b01,
      OWN_HOST = 2'b10
   } dm_owner_t;

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous RAM with a registered read-data port.
// Contents are never reset; rdata only changes on a read.
module dm_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12,
   parameter int DW    = 32
) (
   input  logic          clock,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Write port and registered read port share one address.
   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: core port with priority, four-phase host port,
// sticky error flag and saturating core access counters.
module dm_responder
   import dm_pkg::*;
#(
   parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
   parameter int DATA_WIDTH = DM_DATA_WIDTH,
   parameter int DEPTH      = DM_DEPTH,
   parameter int CNT_WIDTH  = DM_CNT_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  DM_enable,
   input  logic                  DM_read,
   input  logic                  DM_write,
   input  logic [ADDR_WIDTH-1:0] DM_address,
   input  logic [DATA_WIDTH-1:0] DM_in,
   output logic [DATA_WIDTH-1:0] DM_out,
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   host_state_t state, state_nx;
   dm_cmd_t     cmd;
   dm_owner_t   owner, own_q;

   logic                  core_ok, core_bad;
   logic                  host_go, host_drop;
   logic                  in_range, acc_oob;
   logic                  ram_we, ram_re;
   logic                  zero_q;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata, view;
   logic [DATA_WIDTH-1:0] core_hold, host_hold;

   assign core_ok  = DM_enable & (DM_read ^ DM_write);
   assign core_bad = DM_enable & ~(DM_read ^ DM_write);

   // Host FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state <= H_IDLE;
      else       state <= state_nx;
   end

   // Host FSM next state; any core strobe holds the host off.
   always_comb begin
      state_nx = state;
      case (state)
         H_IDLE: if (host_req) state_nx = DM_enable ? H_WAIT : H_ACK;
         H_WAIT: begin
            if (!host_req)       state_nx = H_IDLE;
            else if (!DM_enable) state_nx = H_ACK;
         end
         H_ACK:  if (!host_req) state_nx = H_IDLE;
         default: state_nx = H_IDLE;
      endcase
   end

   // Host FSM outputs: access strobe, protocol drop, acknowledge.
   always_comb begin
      host_go   = 1'b0;
      host_drop = 1'b0;
      host_ack  = 1'b0;
      case (state)
         H_IDLE: host_go = host_req & ~DM_enable;
         H_WAIT: begin
            host_go   = host_req & ~DM_enable;
            host_drop = ~host_req;
         end
         H_ACK:  host_ack = 1'b1;
         default: ;
      endcase
   end

   // Arbitration mux in front of the RAM; core always wins.
   always_comb begin
      cmd       = CMD_NONE;
      owner     = OWN_NONE;
      acc_addr  = DM_address;
      acc_wdata = DM_in;
      if (core_ok) begin
         cmd   = DM_write ? CMD_WRITE : CMD_READ;
         owner = DM_read ? OWN_CORE : OWN_NONE;
      end else if (host_go) begin
         cmd       = host_we ? CMD_WRITE : CMD_READ;
         owner     = host_we ? OWN_NONE : OWN_HOST;
         acc_addr  = host_addr;
         acc_wdata = host_wdata;
      end
   end

   assign in_range = {1'b0, acc_addr} < LIMIT;
   assign acc_oob  = (cmd != CMD_NONE) & ~in_range;
   assign ram_we   = (cmd == CMD_WRITE) & in_range;
   assign ram_re   = (cmd == CMD_READ) & in_range;

   dm_ram #(
      .DEPTH(DEPTH),
      .AW   (RAW),
      .DW   (DATA_WIDTH)
   ) u_ram (
      .clock(clock),
      .we   (ram_we),
      .re   (ram_re),
      .addr (acc_addr[RAW-1:0]),
      .wdata(acc_wdata),
      .rdata(ram_rdata)
   );

   // Error flag, counters and the owner of the last read.
   always_ff @(posedge clock) begin
      if (reset) begin
         err      <= 1'b0;
         rd_count <= '0;
         wr_count <= '0;
         own_q    <= OWN_NONE;
         zero_q   <= 1'b0;
      end else begin
         if (core_bad | acc_oob | host_drop) err <= 1'b1;
         if (core_ok & DM_read & (rd_count != '1))
            rd_count <= rd_count + CNT_WIDTH'(1);
         if (core_ok & DM_write & (wr_count != '1))
            wr_count <= wr_count + CNT_WIDTH'(1);
         own_q  <= owner;
         zero_q <= acc_oob;
      end
   end

   assign view = zero_q ? '0 : ram_rdata;

   // Latch the shared RAM output for whichever side read it last.
   always_ff @(posedge clock) begin
      if (reset) begin
         core_hold <= '0;
         host_hold <= '0;
      end else begin
         if (own_q == OWN_CORE) core_hold <= view;
         if (own_q == OWN_HOST) host_hold <= view;
      end
   end

   assign DM_out     = (own_q == OWN_CORE) ? view : core_hold;
   assign host_rdata = (own_q == OWN_HOST) ? view : host_hold;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder with DEPTH=1024.
// Expected values are hand-computed constants.
module tb_dm_responder;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int CW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          DM_enable, DM_read, DM_write;
   logic [AW-1:0] DM_address;
   logic [DW-1:0] DM_in, DM_out;
   logic          host_req, host_we, host_ack;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          err;
   logic [CW-1:0] rd_count, wr_count;

   int checks = 0;
   int errors = 0;

   dm_responder #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH     (1024),
      .CNT_WIDTH (CW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .DM_enable (DM_enable),
      .DM_read   (DM_read),
      .DM_write  (DM_write),
      .DM_address(DM_address),
      .DM_in     (DM_in),
      .DM_out    (DM_out),
      .host_req  (host_req),
      .host_we   (host_we),
      .host_addr (host_addr),
      .host_wdata(host_wdata),
      .host_ack  (host_ack),
      .host_rdata(host_rdata),
      .err       (err),
      .rd_count  (rd_count),
      .wr_count  (wr_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      DM_enable = 1'b0;
      DM_read   = 1'b0;
      DM_write  = 1'b0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      host_req = 1'b0;
      idle();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic core_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      DM_enable  = 1'b1;
      DM_write   = 1'b1;
      DM_read    = 1'b0;
      DM_address = a;
      DM_in      = d;
      tick();
      idle();
   endtask

   task automatic core_rd(input logic [AW-1:0] a);
      DM_enable  = 1'b1;
      DM_write   = 1'b0;
      DM_read    = 1'b1;
      DM_address = a;
      tick();
      idle();
   endtask

   task automatic host_rd(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] exp);
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = a;
      tick();
      check({tag, "_ack"}, 32'(host_ack), 32'd1);
      check({tag, "_data"}, host_rdata, exp);
      host_req = 1'b0;
      tick();
      check({tag, "_ack_low"}, 32'(host_ack), 32'd0);
   endtask

   initial begin
      DM_address = '0;
      DM_in      = '0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      do_reset();
      check("rst_dm_out", DM_out, 32'h0);
      check("rst_ack", 32'(host_ack), 32'd0);
      check("rst_rdata", host_rdata, 32'h0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rd", 32'(rd_count), 32'd0);
      check("rst_wr", 32'(wr_count), 32'd0);

      core_wr(12'h010, 32'hDEADBEEF);
      check("wr_dm_out", DM_out, 32'h0);
      check("wr_cnt", 32'(wr_count), 32'd1);
      core_rd(12'h010);
      check("rd_data", DM_out, 32'hDEADBEEF);
      check("rd_cnt", 32'(rd_count), 32'd1);
      check("rd_err", 32'(err), 32'd0);
      tick();
      check("rd_hold", DM_out, 32'hDEADBEEF);

      host_req   = 1'b1;
      host_we    = 1'b1;
      host_addr  = 12'h0FF;
      host_wdata = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         DM_enable  = 1'b1;
         DM_read    = 1'b1;
         DM_address = 12'h010;
         tick();
         check("wait_ack", 32'(host_ack), 32'd0);
      end
      idle();
      tick();
      check("wait_done_ack", 32'(host_ack), 32'd1);
      host_req = 1'b0;
      tick();
      check("wait_ack_low", 32'(host_ack), 32'd0);
      check("wait_rd_cnt", 32'(rd_count), 32'd4);
      core_rd(12'h0FF);
      check("host_wr_seen", DM_out, 32'h12345678);
      check("host_wr_err", 32'(err), 32'd0);

      host_rd("hrd", 12'h010, 32'hDEADBEEF);
      check("hrd_dm_out", DM_out, 32'h12345678);
      tick();
      check("hrd_hold", host_rdata, 32'hDEADBEEF);

      DM_enable  = 1'b1;
      DM_read    = 1'b1;
      DM_write   = 1'b1;
      DM_address = 12'h020;
      tick();
      idle();
      check("bad_dm_out", DM_out, 32'h12345678);
      check("bad_err", 32'(err), 32'd1);
      check("bad_rd", 32'(rd_count), 32'd5);
      check("bad_wr", 32'(wr_count), 32'd1);
      tick();
      tick();
      check("bad_sticky", 32'(err), 32'd1);

      do_reset();
      check("rst2_err", 32'(err), 32'd0);
      core_wr(12'h000, 32'hCAFEF00D);
      core_rd(12'h010);
      check("mem_kept", DM_out, 32'hDEADBEEF);
      check("oob_pre_err", 32'(err), 32'd0);
      core_wr(12'h400, 32'hAAAA5555);
      check("oob_wr_err", 32'(err), 32'd1);
      check("oob_wr_cnt", 32'(wr_count), 32'd2);
      core_rd(12'h400);
      check("oob_rd_data", DM_out, 32'h0);
      check("oob_rd_cnt", 32'(rd_count), 32'd2);
      host_rd("h000", 12'h000, 32'hCAFEF00D);
      host_rd("hoob", 12'h7FF, 32'h0);
      check("hoob_dm_out", DM_out, 32'h0);

      host_req   = 1'b1;
      host_we    = 1'b1;
      host_addr  = 12'h055;
      host_wdata = 32'h0BADCAFE;
      tick();
      check("hack_ack", 32'(host_ack), 32'd1);
      reset    = 1'b1;
      host_req = 1'b0;
      tick();
      reset = 1'b0;
      check("rst_ack_ack", 32'(host_ack), 32'd0);
      check("rst_ack_rd", 32'(rd_count), 32'd0);
      check("rst_ack_wr", 32'(wr_count), 32'd0);
      check("rst_ack_err", 32'(err), 32'd0);
      check("rst_ack_out", DM_out, 32'h0);
      core_rd(12'h055);
      check("preload_kept", DM_out, 32'h0BADCAFE);

      do_reset();
      for (int i = 0; i < 32'hFFFE; i++) core_wr(12'h100, 32'(i));
      check("sat_pre", 32'(wr_count), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         core_wr(12'h100, 32'h5A5A0000);
         check("sat_wr", 32'(wr_count), 32'hFFFF);
      end
      check("sat_rd", 32'(rd_count), 32'd0);
      check("sat_err", 32'(err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the TiniSOC core. It is the memory side of the core's `DM_*` interface.
- Serves single-cycle word writes and registered one-cycle-latency reads from the core.
- Adds a four-phase host port, arbitrated behind the core, for testbench or loader preload and dump.
- Keeps sticky protocol-error and access-count status.

It sits beside the core in the SoC top and replaces the behavioural data-memory model.

## Interface
Parameters:
- `ADDR_WIDTH`, 12, word-address width; matches `DM_address`.
- `DATA_WIDTH`, 32, word width.
- `DEPTH`, 4096, number of implemented words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `CNT_WIDTH`, 16, width of the access counters.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `DM_enable` in 1: core access strobe for the current cycle.
- `DM_read` in 1: core read request.
- `DM_write` in 1: core write request.
- `DM_address` in ADDR_WIDTH: core word address.
- `DM_in` in DATA_WIDTH: core write data.
- `DM_out` out DATA_WIDTH: registered read data to the core.
- `host_req` in 1: host request; four-phase.
- `host_we` in 1: host write (1) or read (0); stable while `host_req` is high.
- `host_addr` in ADDR_WIDTH: host word address; stable while `host_req` is high.
- `host_wdata` in DATA_WIDTH: host write data; stable while `host_req` is high.
- `host_ack` out 1: host acknowledge.
- `host_rdata` out DATA_WIDTH: host read data, valid while `host_ack` is high.
- `err` out 1: sticky protocol error.
- `rd_count` out CNT_WIDTH: saturating count of completed core reads.
- `wr_count` out CNT_WIDTH: saturating count of completed core writes.

## Operation
Core port (always has priority):
- A core access is valid when `DM_enable` is high and exactly one of `DM_read` or `DM_write` is high.
- Write: `mem[DM_address] <= DM_in` at the sampling edge; `wr_count` increments.
- Read: `DM_out <= mem[DM_address]` at the sampling edge; `rd_count` increments.
- `DM_out` holds its value until the next core read. Writes and idle cycles do not change it.
- `DM_enable` with both `DM_read` and `DM_write` high, or both low: no memory access, `DM_out` holds, `err` is set.
- Address ≥ DEPTH: a read loads 0 into `DM_out`, a write is dropped, and `err` is set. The counter still increments.
- Counters saturate at all-ones.

Host FSM, with states H_IDLE, H_WAIT and H_ACK:
- H_IDLE, `host_req`=1, `DM_enable`=0: perform the host access this edge and go to H_ACK.
- H_IDLE, `host_req`=1, `DM_enable`=1: go to H_WAIT.
- H_WAIT: at the first edge with `DM_enable`=0, perform the access and go to H_ACK. Otherwise stay in H_WAIT.
- H_ACK: `host_ack`=1. A host read loads `host_rdata` on entry, and it holds until the next host read. When `host_req`=0, go to H_IDLE; `host_ack` falls at that edge.
- `host_req` dropping in H_WAIT is a host protocol violation: go to H_IDLE, drop the access, set `err`.
- Host out-of-range access: a read returns 0, a write is dropped, `err` is set.
- Host accesses never touch the counters.

Reset:
- `DM_out`, `host_rdata`, `host_ack`, `err`, `rd_count` and `wr_count` are all cleared to 0.
- The FSM goes to H_IDLE.
- Memory contents are not cleared.
- A reset mid-handshake abandons the pending host access. The host must deassert `host_req` before issuing a new request.

## Timing
- Core read latency is 1: data addressed at edge k is visible on `DM_out` after edge k. This meets the core's memaccess→writeback stage spacing.
- Core write is visible to a read sampled at edge k+1 or later.
- Host access with no conflict: `host_req` is sampled at edge k, and `host_ack` and `host_rdata` are valid after edge k.
- Each conflicting core cycle adds exactly one cycle of host latency.
- The minimum host handshake is 3 edges: req sampled, ack seen, req low sampled.
- No combinational path exists from any input to any output.

## Structure
- Shared package `dm_pkg` holds:
  - the host FSM state typedef (H_IDLE, H_WAIT, H_ACK);
  - default `ADDR_WIDTH`, `DATA_WIDTH`, `DEPTH` and `CNT_WIDTH` constants;
  - a `dm_cmd` access-kind encoding.
- Sub-module `dm_ram`: single-port synchronous RAM with one address, write enable, write data, and a registered read-data port.
- `dm_responder` holds the arbitration mux in front of `dm_ram`, the host FSM, the range check, the error flag and the counters.
- `dm_ram` read data is steered to `DM_out` or `host_rdata` by an access-owner register.

## Test plan
- Reset, then a core write of 0xDEADBEEF to 0x010, then a core read of 0x010 → `DM_out`=0xDEADBEEF one cycle later; `wr_count`=1, `rd_count`=1, `err`=0.
- Host write of 0x12345678 to 0x0FF while `DM_enable` is held high for 3 cycles → state H_WAIT for 3 cycles, `host_ack` after the first idle edge; a subsequent core read of 0x0FF returns 0x12345678.
- Core read with `DM_read`=`DM_write`=1 at 0x020 → `DM_out` unchanged, `err`=1 and stays 1 until reset.
- With DEPTH=1024, core write to 0x400 followed by a read of 0x400 → `DM_out`=0 and `err`=1; host read of 0x000 is unaffected.
- Preload `wr_count` to 0xFFFE by driving 0xFFFE writes, then do 3 more writes → `wr_count`=0xFFFF and stays there.
- Assert `reset` while in H_ACK with memory preloaded → `host_ack`=0, counters 0, and the preloaded word is still readable after reset.
